// File: rtl/ifmap_pingpong_buffer_if.sv
// ---------------------------------------------------------------------------
// ifmap_pingpong_buffer_if
//  Bus bundle between the ifmap ping-pong buffer and its two clients: the
//  DRAM loader (write channel) and the PE array (read channel).
//
//  Signals
//    wr_valid       loader -> buffer   loader word valid
//    wr_ready       buffer -> loader   buffer can accept a word
//    wr_data        loader -> buffer   loader word
//    rd_en          PE     -> buffer   read request
//    rd_addr        PE     -> buffer   word address within the read bank
//    rd_data        buffer -> PE       read data, one cycle after rd_en
//    rd_data_valid  buffer -> PE       qualifies rd_data
//    addr_err       buffer -> PE       one-cycle pulse on an out-of-range read
//
//  Modports
//    master : the client side (loader + PE array)
//    slave  : the buffer
// ---------------------------------------------------------------------------
interface ifmap_pingpong_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              addr_err;

  modport master (
    output wr_valid, wr_data, rd_en, rd_addr,
    input  wr_ready, rd_data, rd_data_valid, addr_err
  );

  modport slave (
    input  wr_valid, wr_data, rd_en, rd_addr,
    output wr_ready, rd_data, rd_data_valid, addr_err
  );
endinterface

// File: rtl/ifmap_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// ifmap_pingpong_buffer
//  Double-banked input-feature-map buffer sitting between the DRAM loader and
//  the PE array. The loader fills one bank while the PE array reads the other.
//  A bank only goes back to the loader when the controller pulses
//  free_ifmap_buffer (issued once the layer's PE completion count is reached).
//
//  Ports
//    clk                system clock, rising edge
//    rst_n              asynchronous active-low reset
//    start              layer start: synchronous clear, latches cfg_fill_len
//    cfg_fill_len       words per bank for this layer (0 = DEPTH)
//    bus                write/read channels (ifmap_pingpong_buffer_if.slave)
//    bank_full          read bank holds a complete fill
//    free_ifmap_buffer  controller pulse releasing the current read bank
//    free_err           sticky: free seen while the read bank was not FULL
//    parity_err         (IFMAP_BUF_PARITY_EN only) stored-word parity mismatch,
//                       aligned with rd_data_valid
//
//  Optional feature
//    IFMAP_BUF_PARITY_EN : when defined, each stored word carries an even
//    parity bit and the parity_err output exists. Undefined by default.
// ---------------------------------------------------------------------------
module ifmap_pingpong_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W:0]     cfg_fill_len,
  ifmap_pingpong_buffer_if.slave bus,
  output logic                bank_full,
  input  logic                free_ifmap_buffer,
  output logic                free_err
`ifdef IFMAP_BUF_PARITY_EN
  ,
  output logic                parity_err
`endif
);

`ifdef IFMAP_BUF_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;
  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2
  } bank_state_t;

  bank_state_t       bank_state [2];
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   fill_len;
  logic              free_err_q;

  // Read pipeline flags; rd_sel remembers which bank the registered word
  // came from, so a read issued alongside a free returns pre-free data.
  logic              rd_valid_q;
  logic              rd_oob_q;
  logic              addr_err_q;
  logic              rd_sel_q;

  logic              wr_fire;
  logic              wr_last;
  logic              rd_fire;
  logic              rd_oob;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic [ADDR_W:0]   cfg_len;

  // ------------------------------------------------------------------------
  // Combinational control
  // ------------------------------------------------------------------------
  assign bank_full = (bank_state[rd_bank] == BANK_FULL);

  // rst_n gates wr_ready so the loader sees no ready while reset is held.
  assign bus.wr_ready = rst_n && (bank_state[wr_bank] != BANK_FULL) && !start;

  assign wr_fire = bus.wr_valid && bus.wr_ready;
  assign wr_last = (wr_cnt == (fill_len - 1'b1));
  assign rd_fire = bus.rd_en && bank_full && !start;
  assign rd_oob  = ({1'b0, bus.rd_addr} >= fill_len);

  // Zero and anything larger than a bank both mean "use the whole bank";
  // clamping the oversize case keeps wr_cnt from ever aliasing addresses.
  assign cfg_len = ((cfg_fill_len == '0) || (cfg_fill_len > DEPTH_LEN)) ?
                   DEPTH_LEN : cfg_fill_len;

`ifdef IFMAP_BUF_PARITY_EN
  assign wr_word = {^bus.wr_data, bus.wr_data};
`else
  assign wr_word = bus.wr_data;
`endif

  // ------------------------------------------------------------------------
  // Bank storage: one inferred RAM per bank, registered read port
  // ------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [MEM_W-1:0] mem [DEPTH];
      logic [MEM_W-1:0] q;

      always_ff @(posedge clk) begin
        if (wr_fire && (wr_bank == 1'(gi))) begin
          mem[wr_cnt[ADDR_W-1:0]] <= wr_word;
        end
        if (rd_fire && (rd_bank == 1'(gi))) begin
          q <= mem[bus.rd_addr];
        end
      end
    end
  endgenerate

  assign rd_word = rd_sel_q ? g_bank[1].q : g_bank[0].q;

  // Out-of-range reads and idle cycles both present zero; the RAM output
  // register itself carries no reset.
  assign bus.rd_data       = (rd_valid_q && !rd_oob_q) ? rd_word[DATA_W-1:0] : '0;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.addr_err      = addr_err_q;
  assign free_err          = free_err_q;

`ifdef IFMAP_BUF_PARITY_EN
  // Stored word is {parity, data} with even parity over the whole word.
  assign parity_err = rd_valid_q && !rd_oob_q && (^rd_word);
`endif

  // ------------------------------------------------------------------------
  // Bank state machine and counters
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        bank_state[b] <= BANK_EMPTY;
      end
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      fill_len   <= DEPTH_LEN;
      free_err_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      addr_err_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else if (start) begin
      for (int b = 0; b < 2; b++) begin
        bank_state[b] <= BANK_EMPTY;
      end
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      fill_len   <= cfg_len;
      free_err_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      addr_err_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      rd_oob_q   <= rd_fire && rd_oob;
      addr_err_q <= rd_fire && rd_oob;
      if (rd_fire) begin
        rd_sel_q <= rd_bank;
      end

      if (wr_fire) begin
        if (wr_last) begin
          bank_state[wr_bank] <= BANK_FULL;
          wr_cnt              <= '0;
          wr_bank             <= ~wr_bank;
        end else begin
          bank_state[wr_bank] <= BANK_FILL;
          wr_cnt              <= wr_cnt + 1'b1;
        end
      end

      // A write never targets a FULL bank, so a legal free and a write in the
      // same cycle always touch different bank_state entries.
      if (free_ifmap_buffer) begin
        if (bank_full) begin
          bank_state[rd_bank] <= BANK_EMPTY;
          rd_bank             <= ~rd_bank;
        end else begin
          free_err_q <= 1'b1;
        end
      end
    end
  end

endmodule
